// File: rtl/tjmono_rx_seq.sv
// Token-driven readout sequencer for TJ-Monopix-style matrices: freeze/read
// handshake, multi-hit frames, token-edge timestamp, serial deserializer with
// optional Gray decode, and a first-word fall-through output FIFO.
module tjmono_rx_seq #(
    parameter int unsigned DATA_WIDTH = 27,
    parameter int unsigned ROW_BITS   = 9,
    parameter int unsigned GRAY_BITS  = 6,
    parameter int unsigned TS_WIDTH   = 52,
    parameter int unsigned CW         = 8,
    parameter int unsigned RD_LAT     = 4,
    parameter int unsigned FIFO_ASIZE = 3
) (
    input  logic                               RX_CLK,
    input  logic                               RST_N,
    input  logic                               CONF_EN,
    input  logic                               CONF_GRAY_DEC,
    input  logic [CW-1:0]                      CONF_START_FREEZE,
    input  logic [CW-1:0]                      CONF_START_READ,
    input  logic [CW-1:0]                      CONF_STOP_READ,
    input  logic [CW-1:0]                      CONF_STOP,
    input  logic [7:0]                         CONF_MAX_HITS,
    input  logic [TS_WIDTH-1:0]                TIMESTAMP,
    input  logic                               RX_TOKEN,
    input  logic                               RX_DATA,
    output logic                               RX_FREEZE,
    output logic                               RX_READ,
    output logic                               READY,
    output logic [8+TS_WIDTH+DATA_WIDTH-1:0]   DATA_OUT,
    output logic                               DATA_VALID,
    input  logic                               DATA_READY,
    output logic [7:0]                         LOST_CNT
);
    localparam int unsigned OW    = 8 + TS_WIDTH + DATA_WIDTH;
    localparam int unsigned BCW   = $clog2(DATA_WIDTH);
    localparam int unsigned DEPTH = 2 ** FIFO_ASIZE;

    typedef enum logic [1:0] {ST_IDLE, ST_FRAME, ST_RELEASE} state_t;

    state_t                state_q, state_d;
    logic [2:0]            tok_q;
    logic                  token_s, token_rise;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [7:0]            hit_idx_q, hit_idx_d;
    logic                  freeze_q, freeze_d;
    logic                  read_q, read_d;
    logic [TS_WIDTH-1:0]   ts_lat_q, ts_lat_d;
    logic [TS_WIDTH-1:0]   frame_ts_q, frame_ts_d;
    logic                  limit_hit, next_hit;
    logic [CW-1:0]         sample_at;

    logic [DATA_WIDTH-1:0] sr_q, word_dec;
    logic [BCW-1:0]        bcnt_q;
    logic                  busy_q, push_q, sample_start;

    logic [OW-1:0]         mem_q [DEPTH];
    logic [FIFO_ASIZE:0]   wptr_q, rptr_q;
    logic [7:0]            lost_q;
    logic                  fifo_empty, fifo_full, do_pop, do_push;

    assign token_s    = tok_q[1];
    assign token_rise = tok_q[1] & ~tok_q[2];
    assign sample_at  = CONF_STOP_READ + CW'(RD_LAT);
    assign limit_hit  = (CONF_MAX_HITS != 8'd0) && ((hit_idx_q + 8'd1) == CONF_MAX_HITS);
    assign next_hit   = token_s && CONF_EN && !limit_hit;

    // State register plus all sequencer registers and the token synchroniser
    always_ff @(posedge RX_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            tok_q      <= '0;
            cnt_q      <= '0;
            hit_idx_q  <= '0;
            freeze_q   <= 1'b0;
            read_q     <= 1'b0;
            ts_lat_q   <= '0;
            frame_ts_q <= '0;
        end else begin
            state_q    <= state_d;
            tok_q      <= {tok_q[1:0], RX_TOKEN};
            cnt_q      <= cnt_d;
            hit_idx_q  <= hit_idx_d;
            freeze_q   <= freeze_d;
            read_q     <= read_d;
            ts_lat_q   <= ts_lat_d;
            frame_ts_q <= frame_ts_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (token_s && CONF_EN) state_d = ST_FRAME;
            ST_FRAME:   if (cnt_q == CONF_STOP && !next_hit) state_d = ST_RELEASE;
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Frame counter, hit index, freeze/read controls and timestamp latching
    always_comb begin
        cnt_d      = '0;
        hit_idx_d  = hit_idx_q;
        freeze_d   = freeze_q;
        read_d     = 1'b0;
        // RELEASE also latches so a frame restarted by a still-high token gets a fresh stamp
        ts_lat_d   = (token_rise || state_q == ST_RELEASE) ? TIMESTAMP : ts_lat_q;
        frame_ts_d = frame_ts_q;
        unique case (state_q)
            ST_IDLE: begin
                if (token_s && CONF_EN) begin
                    hit_idx_d  = '0;
                    frame_ts_d = ts_lat_d;
                end
            end
            ST_FRAME: begin
                read_d = (cnt_q >= CONF_START_READ) && (cnt_q < CONF_STOP_READ);
                if (cnt_q == CONF_START_FREEZE) freeze_d = 1'b1;
                if (cnt_q == CONF_STOP) begin
                    if (next_hit) begin
                        hit_idx_d = hit_idx_q + 8'd1;
                        cnt_d     = CONF_START_READ;
                    end
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_RELEASE: freeze_d = 1'b0;
            default: ;
        endcase
    end

    assign sample_start = (state_q == ST_FRAME) && (cnt_q == sample_at) && !busy_q;

    // Serial deserializer: MSB first, push pulse the cycle after the last bit
    always_ff @(posedge RX_CLK or negedge RST_N) begin
        if (!RST_N) begin
            sr_q   <= '0;
            bcnt_q <= '0;
            busy_q <= 1'b0;
            push_q <= 1'b0;
        end else begin
            push_q <= 1'b0;
            if (sample_start || busy_q) sr_q <= {sr_q[DATA_WIDTH-2:0], RX_DATA};
            if (sample_start) begin
                busy_q <= 1'b1;
                bcnt_q <= BCW'(1);
            end else if (busy_q) begin
                if (bcnt_q == BCW'(DATA_WIDTH - 1)) begin
                    busy_q <= 1'b0;
                    bcnt_q <= '0;
                    push_q <= 1'b1;
                end else begin
                    bcnt_q <= bcnt_q + BCW'(1);
                end
            end
        end
    end

    // Gray-to-binary on the LE and TE fields as a running XOR from each field MSB down
    always_comb begin
        logic acc;
        word_dec = sr_q;
        acc      = 1'b0;
        if (CONF_GRAY_DEC) begin
            for (int unsigned f = 0; f < 2; f++) begin
                acc = 1'b0;
                for (int unsigned i = 0; i < GRAY_BITS; i++) begin
                    acc = acc ^ sr_q[ROW_BITS + f*GRAY_BITS + GRAY_BITS - 1 - i];
                    word_dec[ROW_BITS + f*GRAY_BITS + GRAY_BITS - 1 - i] = acc;
                end
            end
        end
    end

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[FIFO_ASIZE] != rptr_q[FIFO_ASIZE]) &&
                        (wptr_q[FIFO_ASIZE-1:0] == rptr_q[FIFO_ASIZE-1:0]);
    assign do_pop     = !fifo_empty && DATA_READY;
    assign do_push    = push_q && (!fifo_full || do_pop);

    // FIFO storage, no reset needed since reads are gated by the empty flag
    always_ff @(posedge RX_CLK) begin
        if (do_push) mem_q[wptr_q[FIFO_ASIZE-1:0]] <= {hit_idx_q, frame_ts_q, word_dec};
    end

    // FIFO pointers and saturating loss counter
    always_ff @(posedge RX_CLK or negedge RST_N) begin
        if (!RST_N) begin
            wptr_q <= '0;
            rptr_q <= '0;
            lost_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            if (push_q && !do_push && lost_q != 8'hFF) lost_q <= lost_q + 8'd1;
        end
    end

    assign RX_FREEZE  = freeze_q;
    assign RX_READ    = read_q;
    assign READY      = RST_N & ~freeze_q & CONF_EN;
    assign DATA_VALID = !fifo_empty;
    assign DATA_OUT   = fifo_empty ? '0 : mem_q[rptr_q[FIFO_ASIZE-1:0]];
    assign LOST_CNT   = lost_q;

endmodule

// File: tb/tb_tjmono_rx_seq.sv
// Directed bench for tjmono_rx_seq: a small chip model serves serial words
// after each RX_READ pulse, a monitor collects accepted FIFO words.
module tb_tjmono_rx_seq;
    localparam int DW  = 27;
    localparam int TSW = 52;
    localparam int OW  = 8 + TSW + DW;
    localparam int RDL = 4;

    logic           clk = 1'b0;
    logic           rst_n, conf_en, gray_dec, token, rx_data, data_ready;
    logic [7:0]     sfrz, srd, sprd, stp, max_hits;
    logic [TSW-1:0] ts;
    logic           freeze, rd, ready, valid;
    logic [OW-1:0]  dout;
    logic [7:0]     lost;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] tx_q [$];
    logic [OW-1:0] rx_q [$];

    always #5 clk = ~clk;

    tjmono_rx_seq dut (
        .RX_CLK(clk), .RST_N(rst_n), .CONF_EN(conf_en), .CONF_GRAY_DEC(gray_dec),
        .CONF_START_FREEZE(sfrz), .CONF_START_READ(srd), .CONF_STOP_READ(sprd),
        .CONF_STOP(stp), .CONF_MAX_HITS(max_hits), .TIMESTAMP(ts),
        .RX_TOKEN(token), .RX_DATA(rx_data), .RX_FREEZE(freeze), .RX_READ(rd),
        .READY(ready), .DATA_OUT(dout), .DATA_VALID(valid), .DATA_READY(data_ready),
        .LOST_CNT(lost)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OW-1:0] rx_word(input int i);
        if (i < rx_q.size()) return rx_q[i];
        return '0;
    endfunction

    // Chip model: RD_LAT cycles after the last read cycle, shift one word MSB first
    initial begin
        logic          prev_rd;
        logic [DW-1:0] w;
        rx_data = 1'b0;
        prev_rd = 1'b0;
        forever begin
            tick();
            if (prev_rd && !rd) begin
                repeat (RDL - 1) tick();
                w = (tx_q.size() > 0) ? tx_q.pop_front() : '0;
                for (int i = DW - 1; i >= 0; i--) begin
                    rx_data = w[i];
                    tick();
                end
                rx_data = 1'b0;
            end
            prev_rd = rd;
        end
    end

    // Output monitor: record each word accepted by the consumer
    always @(negedge clk) begin
        if (rst_n && valid && data_ready) rx_q.push_back(dout);
    end

    task automatic run_frame(input int cycles, input int drop_at, input int ts_at,
                             input logic [TSW-1:0] ts_new,
                             output int frz_rise, output int frz_fall, output int rd_cnt,
                             output int rd_first, output int vld_first);
        frz_rise = -1; frz_fall = -1; rd_cnt = 0; rd_first = -1; vld_first = -1;
        token = 1'b1;
        for (int n = 1; n <= cycles; n++) begin
            tick();
            if (n == drop_at) token = 1'b0;
            if (n == ts_at) ts = ts_new;
            if (freeze && frz_rise < 0) frz_rise = n;
            if (!freeze && frz_rise >= 0 && frz_fall < 0) frz_fall = n;
            if (rd) begin
                rd_cnt++;
                if (rd_first < 0) rd_first = n;
            end
            if (valid && vld_first < 0) vld_first = n;
        end
    endtask

    initial begin
        int fr, ff, rc, rf, vf;
        logic [OW-1:0] w;
        logic [DW-1:0] gin, gexp;

        rst_n = 1'b0; conf_en = 1'b1; gray_dec = 1'b0; token = 1'b0; data_ready = 1'b1;
        sfrz = 8'd3; srd = 8'd6; sprd = 8'd7; stp = 8'd45; max_hits = 8'd0; ts = '0;
        repeat (3) tick();
        chk("rst_freeze", freeze, 1'b0);
        chk("rst_read", rd, 1'b0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_lost", lost, 8'd0);
        chk("rst_ready", ready, 1'b0);
        chk("rst_dout", dout, '0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_ready", ready, 1'b1);

        // Single token pulse with default timing
        ts = 52'h1_2345_6789_ABCD;
        tx_q.delete(); rx_q.delete();
        tx_q.push_back(27'h5A5A5A5);
        run_frame(60, 4, 0, '0, fr, ff, rc, rf, vf);
        chk("t1_frz_rise", fr, 7);
        chk("t1_frz_fall", ff, 50);
        chk("t1_rd_cnt", rc, 1);
        chk("t1_rd_first", rf, 10);
        chk("t1_valid_rise", vf, 42);
        chk("t1_nwords", rx_q.size(), 1);
        w = rx_word(0);
        chk("t1_idx", w[OW-1 -: 8], 8'd0);
        chk("t1_ts", w[DW +: TSW], 52'h1_2345_6789_ABCD);
        chk("t1_data", w[DW-1:0], 27'h5A5A5A5);
        repeat (5) tick();

        // Token held for three hits, unlimited
        ts = 52'h0_0000_0000_2222;
        tx_q.delete(); rx_q.delete();
        for (int i = 0; i < 3; i++) tx_q.push_back(27'h1000000 + 27'(i));
        run_frame(150, 100, 20, 52'h0_0000_0000_9999, fr, ff, rc, rf, vf);
        chk("t2_frz_rise", fr, 7);
        chk("t2_frz_fall", ff, 130);
        chk("t2_rd_cnt", rc, 3);
        chk("t2_nwords", rx_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            w = rx_word(i);
            chk($sformatf("t2_idx%0d", i), w[OW-1 -: 8], 8'(i));
            chk($sformatf("t2_ts%0d", i), w[DW +: TSW], 52'h0_0000_0000_2222);
            chk($sformatf("t2_data%0d", i), w[DW-1:0], 27'h1000000 + 27'(i));
        end
        repeat (5) tick();

        // Hit limit 2 with token held: release, then a fresh frame
        max_hits = 8'd2;
        ts = 52'h0_0000_0000_3A3A;
        tx_q.delete(); rx_q.delete();
        for (int i = 0; i < 3; i++) tx_q.push_back(27'h2000000 + 27'(i));
        run_frame(160, 110, 60, 52'h0_0000_0000_3B3B, fr, ff, rc, rf, vf);
        chk("t3_frz_fall", ff, 90);
        chk("t3_nwords", rx_q.size(), 3);
        w = rx_word(0);
        chk("t3_idx0", w[OW-1 -: 8], 8'd0);
        chk("t3_ts0", w[DW +: TSW], 52'h0_0000_0000_3A3A);
        w = rx_word(1);
        chk("t3_idx1", w[OW-1 -: 8], 8'd1);
        chk("t3_ts1", w[DW +: TSW], 52'h0_0000_0000_3A3A);
        w = rx_word(2);
        chk("t3_idx2", w[OW-1 -: 8], 8'd0);
        chk("t3_ts2", w[DW +: TSW], 52'h0_0000_0000_3B3B);
        chk("t3_data2", w[DW-1:0], 27'h2000002);
        max_hits = 8'd0;
        repeat (5) tick();

        // Gray decode: col 101011, TE gray 000011, LE gray 100000, row 1A5
        gray_dec = 1'b1;
        gin  = {6'b101011, 6'b000011, 6'b100000, 9'h1A5};
        gexp = {6'b101011, 6'b000010, 6'b111111, 9'h1A5};
        tx_q.delete(); rx_q.delete();
        tx_q.push_back(gin);
        run_frame(60, 4, 0, '0, fr, ff, rc, rf, vf);
        w = rx_word(0);
        chk("t4_nwords", rx_q.size(), 1);
        chk("t4_le", w[14:9], 6'b111111);
        chk("t4_data", w[DW-1:0], gexp);
        gray_dec = 1'b0;
        repeat (5) tick();

        // Ten hits with consumer stalled: 8 kept, 2 lost
        data_ready = 1'b0;
        tx_q.delete(); rx_q.delete();
        for (int i = 0; i < 10; i++) tx_q.push_back(27'h0ABC000 + 27'(i));
        run_frame(420, 380, 0, '0, fr, ff, rc, rf, vf);
        chk("t5_lost", lost, 8'd2);
        chk("t5_valid", valid, 1'b1);
        chk("t5_head_idx", dout[OW-1 -: 8], 8'd0);
        data_ready = 1'b1;
        repeat (12) tick();
        chk("t5_nwords", rx_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            w = rx_word(i);
            chk($sformatf("t5_idx%0d", i), w[OW-1 -: 8], 8'(i));
            chk($sformatf("t5_data%0d", i), w[DW-1:0], 27'h0ABC000 + 27'(i));
        end
        chk("t5_empty", valid, 1'b0);

        // Reset at frame cycle 20, token kept high
        ts = 52'h0_0000_0000_6A6A;
        tx_q.delete(); rx_q.delete();
        tx_q.push_back(27'h3333333);
        tx_q.push_back(27'h4444444);
        token = 1'b1;
        repeat (23) tick();
        chk("t6_pre_freeze", freeze, 1'b1);
        chk("t6_pre_lost", lost, 8'd2);
        rst_n = 1'b0;
        #1;
        chk("t6_freeze", freeze, 1'b0);
        chk("t6_read", rd, 1'b0);
        chk("t6_valid", valid, 1'b0);
        chk("t6_lost", lost, 8'd0);
        chk("t6_ready", ready, 1'b0);
        chk("t6_dout", dout, '0);
        repeat (10) tick();
        ts = 52'h0_0000_0000_6B6B;
        rst_n = 1'b1;
        for (int n = 1; n <= 70; n++) begin
            tick();
            if (n == 15) token = 1'b0;
        end
        chk("t6_nwords", rx_q.size(), 1);
        w = rx_word(0);
        chk("t6_idx", w[OW-1 -: 8], 8'd0);
        chk("t6_ts", w[DW +: TSW], 52'h0_0000_0000_6B6B);
        chk("t6_data", w[DW-1:0], 27'h4444444);
        repeat (5) tick();

        // Loss counter saturation with about 300 drops
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        stp = 8'd39;
        data_ready = 1'b0;
        tx_q.delete(); rx_q.delete();
        token = 1'b1;
        repeat (10500) tick();
        token = 1'b0;
        repeat (100) tick();
        chk("t7_lost_sat", lost, 8'd255);
        chk("t7_valid", valid, 1'b1);
        chk("t7_head_idx", dout[OW-1 -: 8], 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
